aes_mixcol_seq: RTL and testbench

AES_MIXCOL_SEQ -- requirements
Module: aes_mixcol_seq

---
 rtl/aes_mixcol_seq_if.sv | 20 ++
 rtl/aes_mixcol_seq.sv | 109 ++++++++++
 tb/tb_aes_mixcol_seq.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_mixcol_seq_if.sv
// Handshake/data bundle for aes_mixcol_seq: state in, MixColumns result out.
interface aes_mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         inv_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, inv_mode, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, inv_mode, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_mixcol_seq.sv
// Sequential AES MixColumns, one column per cycle using xtime/XOR only.
// Optional InvMixColumns support is enabled by defining AES_MIXCOL_INV_EN.
module aes_mixcol_seq (
  input logic             clk,
  input logic             rst_n,
  aes_mixcol_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q;
  logic [127:0] st_q;
  logic [127:0] out_q;
  logic [6:0]   lsb;
  logic [31:0]  col;
  logic [31:0]  res;
`ifdef AES_MIXCOL_INV_EN
  logic         inv_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
            xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
  endfunction

`ifdef AES_MIXCOL_INV_EN
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] b [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]   = c[31-8*i -: 8];
      x2     = xt(b[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ b[i];
      m11[i] = x8 ^ x2 ^ b[i];
      m13[i] = x8 ^ x4 ^ b[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction
`endif

  // Column c lives at bits [127-32c -: 32]; its LSB index is 32*(3-c).
  assign lsb = {~cnt_q, 5'd0};
  assign col = st_q[lsb +: 32];

  always_comb begin
    res = fwd_col(col);
`ifdef AES_MIXCOL_INV_EN
    if (inv_q) res = inv_col(col);
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid)   state_d = StCalc;
      StCalc:  if (cnt_q == 2'd3)  state_d = StDone;
      StDone:  if (bus.out_ready)  state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_state = out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      st_q    <= '0;
      out_q   <= '0;
`ifdef AES_MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.in_valid) begin
        st_q  <= bus.in_state;
        cnt_q <= 2'd0;
`ifdef AES_MIXCOL_INV_EN
        inv_q <= bus.inv_mode;
`endif
      end else if (state_q == StCalc) begin
        out_q[lsb +: 32] <= res;
        cnt_q            <= cnt_q + 2'd1;  // wraps to 0 after column 3
      end
    end
  end

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Self-checking bench for aes_mixcol_seq: directed vectors plus random traffic
// checked against a GF(2^8) matrix-multiply reference model.
module tb_aes_mixcol_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  aes_mixcol_seq_if bus ();

  aes_mixcol_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    logic         use_inv = 1'b0;
`ifdef AES_MIXCOL_INV_EN
    use_inv = inv;
`else
    use_inv = 1'b0 & inv;
`endif
    if (use_inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else         begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(m[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    return r;
  endfunction

  // Clocks after the accept edge until out_valid; 0 on timeout.
  task automatic run(input logic [127:0] s, input logic inv, input bit randomize_late,
                     output logic [127:0] got, output int lat);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    check("wait_in_ready", 128'(bus.in_ready), 128'd1);
    bus.in_valid = 1'b1;
    bus.in_state = s;
    bus.inv_mode = inv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (randomize_late) begin
      bus.inv_mode = 1'($urandom);
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin lat = i; break; end
    end
    got = bus.out_state;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  logic [127:0] got, hold, s;
  logic         inv;
  int           lat, seen, acc_cyc[2], nacc, nres, cyc;
  logic [127:0] b2b_in[2], b2b_exp[2];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.inv_mode  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_out_state", bus.out_state, 128'd0);
    rst_n = 1'b1;

    // FIPS-197 forward vector
    run(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 1'b0, got, lat);
    check("fips_fwd", got, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    check("fips_fwd_lat", 128'(lat), 128'd4);

    run(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, 1'b0, got, lat);
`ifdef AES_MIXCOL_INV_EN
    check("fips_inv", got, 128'hdb135345_f20a225c_01010101_2d26314c);
`else
    check("fips_inv_ignored", got, ref_mix(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0));
`endif
    check("fips_inv_lat", 128'(lat), 128'd4);

    // xtime reduction corners
    run({4{32'h80808080}}, 1'b0, 1'b0, got, lat);
    check("xtime_8080", got, {4{32'h80808080}});
    run({32'h80000000, 32'h80808080, 32'h80000000, 32'h00000000}, 1'b0, 1'b0, got, lat);
    check("xtime_8000", got, {32'h1b80809b, 32'h80808080, 32'h1b80809b, 32'h00000000});

    // Backpressure in DONE with input churn
    bus.in_valid = 1'b1;
    bus.in_state = 128'h00112233_44556677_8899aabb_ccddeeff;
    bus.inv_mode = 1'b0;
    @(posedge clk); #1;
    repeat (4) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    check("bp_enter_done", 128'(bus.out_valid), 128'd1);
    hold = ref_mix(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_state = {$urandom, $urandom, $urandom, $urandom};
      bus.inv_mode = ~bus.inv_mode;
      @(posedge clk); #1;
      check("bp_state", bus.out_state, hold);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_hs_in_ready", 128'(bus.in_ready), 128'd1);
    check("post_hs_out_valid", 128'(bus.out_valid), 128'd0);
    check("post_hs_retain", bus.out_state, hold);

    // Reset after column 1
    bus.in_valid = 1'b1;
    bus.in_state = 128'hdb135345_f20a225c_01010101_2d26314c;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst_out_state", bus.out_state, 128'd0);
    seen = 0;
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    bus.out_ready = 1'b0;
    check("midrst_no_valid", 128'(seen), 128'd0);

    // Back-to-back with both handshakes held high
    b2b_in[0] = {4{32'hc6c6c6c6}};  b2b_exp[0] = {4{32'hc6c6c6c6}};
    b2b_in[1] = {4{32'hd4d4d4d5}};  b2b_exp[1] = {4{32'hd5d5d7d6}};
    bus.in_valid  = 1'b1;
    bus.in_state  = b2b_in[0];
    bus.inv_mode  = 1'b0;
    bus.out_ready = 1'b1;
    nacc = 0; nres = 0; cyc = 0;
    while (cyc < 40 && !(nacc == 2 && nres == 2)) begin
      if (bus.out_valid && nres < 2) begin
        check("b2b_result", bus.out_state, b2b_exp[nres]);
        nres++;
      end
      seen = int'(bus.in_ready && bus.in_valid);
      @(posedge clk); #1;
      cyc++;
      if (seen != 0 && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc == 2) bus.in_valid = 1'b0;
        else bus.in_state = b2b_in[1];
      end
    end
    bus.out_ready = 1'b0;
    check("b2b_counts", 128'({nacc, nres}), 128'({32'd2, 32'd2}));
    check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
    @(posedge clk); #1;

    // Random traffic, inputs scrambled after capture
    for (int t = 0; t < 20; t++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom);
      run(s, inv, 1'b1, got, lat);
      check("rand_result", got, ref_mix(s, inv));
      check("rand_lat", 128'(lat), 128'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
